// File: rtl/rx_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// rx_ctrl_fsm - receive-side sequencer for the RX engine.
//
// Synchronizes the asynchronous serial line, qualifies the start bit at its
// mid-point using the oversample tick, then emits one-cycle shift strobes at
// the middle of every frame bit (data, optional parity, stop) followed by a
// one-cycle ld strobe. Frame length is latched when a start is detected.
//
// Ports:
//   Clk         in   system clock, rising edge
//   Rst         in   synchronous active-low reset
//   baud_k      in   oversample tick, OVERSAMPLE ticks per bit
//   rx_en       in   receiver enable, only gates new start detection
//   Rx_in       in   asynchronous serial line (idle high)
//   bit8_en     in   1 = 8 data bits, 0 = 7 data bits
//   parity_en   in   1 = parity bit follows the data bits
//   shift       out  one-Clk strobe: shift rx_bit into the SIPO
//   rx_bit      out  synchronized serial bit
//   ld          out  one-Clk strobe: frame complete
//   busy        out  high while a frame is in progress
//   false_start out  one-Clk pulse: start bit was high at its mid-point
// -----------------------------------------------------------------------------
module rx_ctrl_fsm #(
    parameter int OVERSAMPLE = 16,
    parameter int TCNT_W     = 4
) (
    input  logic Clk,
    input  logic Rst,
    input  logic baud_k,
    input  logic rx_en,
    input  logic Rx_in,
    input  logic bit8_en,
    input  logic parity_en,
    output logic shift,
    output logic rx_bit,
    output logic ld,
    output logic busy,
    output logic false_start
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_LOAD  = 2'd3
    } state_t;

    localparam logic [TCNT_W-1:0] TICK_HALF = TCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TCNT_W-1:0] TICK_FULL = TCNT_W'(OVERSAMPLE - 1);
    localparam logic [TCNT_W-1:0] TICK_ONE  = TCNT_W'(1);
    localparam logic [TCNT_W-1:0] TICK_ZERO = TCNT_W'(0);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_sync1;
    logic              r_sync2;
    logic [TCNT_W-1:0] r_tick_cnt;
    logic [TCNT_W-1:0] w_tick_nxt;
    logic [3:0]        r_bit_cnt;
    logic [3:0]        w_bit_nxt;
    logic [3:0]        r_nbits;
    logic [3:0]        w_nbits_nxt;
    logic              w_tick_half;
    logic              w_tick_full;
    logic              w_shift_nxt;
    logic              w_ld_nxt;
    logic              w_fs_nxt;
    logic              w_busy_nxt;
    logic              r_shift;
    logic              r_ld;
    logic              r_fs;
    logic              r_busy;

    assign w_tick_half = (r_tick_cnt == TICK_HALF);
    assign w_tick_full = (r_tick_cnt == TICK_FULL);

    assign rx_bit      = r_sync2;
    assign shift       = r_shift;
    assign ld          = r_ld;
    assign busy        = r_busy;
    assign false_start = r_fs;

    // State register: synchronizer, FSM state, counters and registered strobes
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_state    <= ST_IDLE;
            r_tick_cnt <= TICK_ZERO;
            r_bit_cnt  <= 4'd0;
            r_nbits    <= 4'd0;
            r_shift    <= 1'b0;
            r_ld       <= 1'b0;
            r_fs       <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_sync1    <= Rx_in;
            r_sync2    <= r_sync1;
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_nbits    <= w_nbits_nxt;
            r_shift    <= w_shift_nxt;
            r_ld       <= w_ld_nxt;
            r_fs       <= w_fs_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // Next-state logic: transitions plus tick/bit counter and frame-length updates
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_nbits_nxt = r_nbits;
        case (r_state)
            ST_IDLE: begin
                // Start detection does not wait for a tick; the half-bit
                // count in START provides the mid-bit alignment.
                if (rx_en && !r_sync2) begin
                    w_state_nxt = ST_START;
                    w_tick_nxt  = TICK_ZERO;
                    w_nbits_nxt = 4'd8 + {3'd0, bit8_en} + {3'd0, parity_en};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_k) begin
                    if (w_tick_half) begin
                        if (!r_sync2) begin
                            w_state_nxt = ST_DATA;
                            w_tick_nxt  = TICK_ZERO;
                            w_bit_nxt   = 4'd0;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + TICK_ONE;
                    end
                end else begin
                    w_state_nxt = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_k) begin
                    if (w_tick_full) begin
                        w_tick_nxt = TICK_ZERO;
                        w_bit_nxt  = r_bit_cnt + 4'd1;
                        // The stop bit is the last sample of the frame.
                        if (r_bit_cnt == (r_nbits - 4'd1)) begin
                            w_state_nxt = ST_LOAD;
                        end else begin
                            w_state_nxt = ST_DATA;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + TICK_ONE;
                    end
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered strobes and busy flag
    always_comb begin
        w_shift_nxt = 1'b0;
        w_ld_nxt    = 1'b0;
        w_fs_nxt    = 1'b0;
        case (r_state)
            ST_START: begin
                if (baud_k && w_tick_half && r_sync2) begin
                    w_fs_nxt = 1'b1;
                end else begin
                    w_fs_nxt = 1'b0;
                end
            end
            ST_DATA: begin
                if (baud_k && w_tick_full) begin
                    w_shift_nxt = 1'b1;
                end else begin
                    w_shift_nxt = 1'b0;
                end
            end
            ST_LOAD: begin
                w_ld_nxt = 1'b1;
            end
            default: begin
                w_shift_nxt = 1'b0;
            end
        endcase
        // Busy stays up through the ld cycle and drops on the one after.
        w_busy_nxt = (w_state_nxt != ST_IDLE) || w_ld_nxt;
    end

endmodule

// File: tb/tb_rx_ctrl_fsm.sv
module tb_rx_ctrl_fsm;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    logic baud_k = 1'b0;
    logic rx_en = 1'b1;
    logic Rx_in = 1'b1;
    logic bit8_en = 1'b1;
    logic parity_en = 1'b0;
    logic shift, rx_bit, ld, busy, false_start;

    rx_ctrl_fsm #(.OVERSAMPLE(16), .TCNT_W(4)) dut (
        .Clk(Clk), .Rst(Rst), .baud_k(baud_k), .rx_en(rx_en), .Rx_in(Rx_in),
        .bit8_en(bit8_en), .parity_en(parity_en), .shift(shift), .rx_bit(rx_bit),
        .ld(ld), .busy(busy), .false_start(false_start)
    );

    always #5 Clk = ~Clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int bcnt   = 0;
    int overlap_cnt = 0;
    int edge_a, edge_b;
    logic sender_done;
    logic prev_ld = 1'b0;

    int   sh_cyc[$];
    logic sh_bit[$];
    int   ld_cyc[$];
    logic ld_busy[$];
    logic post_busy[$];
    int   fs_cyc[$];
    logic fs_busy[$];

    typedef struct {
        logic       b8;
        logic       par;
        logic [9:0] word;   // bit i = i-th bit after the start bit, stop included
        int         nsh;    // expected shift count = frame bits after start
    } vec_t;
    vec_t vecs[4];

    // Cycle counter: number of rising edges so far
    initial forever begin
        @(posedge Clk);
        cyc = cyc + 1;
    end

    // Oversample tick: one Clk high every 4 Clk
    initial forever begin
        @(negedge Clk);
        bcnt   = bcnt + 1;
        baud_k = ((bcnt % 4) == 0);
    end

    // Output monitor, sampled on the falling edge
    initial forever begin
        @(negedge Clk);
        if (shift === 1'b1) begin sh_cyc.push_back(cyc); sh_bit.push_back(rx_bit); end
        if (ld === 1'b1) begin ld_cyc.push_back(cyc); ld_busy.push_back(busy); end
        if (prev_ld) post_busy.push_back(busy);
        prev_ld = (ld === 1'b1);
        if (false_start === 1'b1) begin fs_cyc.push_back(cyc); fs_busy.push_back(busy); end
        if (shift === 1'b1 && ld === 1'b1) overlap_cnt = overlap_cnt + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_q();
        sh_cyc.delete(); sh_bit.delete(); ld_cyc.delete(); ld_busy.delete();
        post_busy.delete(); fs_cyc.delete(); fs_busy.delete();
    endtask

    // Sends start bit then nbits bits of word; caller is on a falling edge
    task automatic send_frame(input logic [9:0] word, input int nbits, output int edge_c);
        Rx_in  = 1'b0;
        edge_c = cyc;
        repeat (64) @(negedge Clk);
        for (int i = 0; i < nbits; i++) begin
            Rx_in = word[i];
            repeat (64) @(negedge Clk);
        end
        Rx_in = 1'b1;
    endtask

    // Checks the shift/ld record of one frame starting at shift index base
    task automatic check_frame(input string name, input int base, input int ld_idx,
                               input int edge_c, input logic [9:0] word, input int nsh);
        int off;
        if (sh_cyc.size() >= base + nsh) begin
            off = sh_cyc[base] - edge_c;
            chk({name, "_first_shift_in_window"}, int'(off >= 92 && off <= 100), 1);
            for (int i = 0; i < nsh; i++) begin
                chk($sformatf("%s_bit%0d", name, i), int'(sh_bit[base + i]), int'(word[i]));
                if (i > 0) chk($sformatf("%s_gap%0d", name, i),
                               sh_cyc[base + i] - sh_cyc[base + i - 1], 64);
            end
            if (ld_cyc.size() > ld_idx)
                chk({name, "_ld_after_last_shift"}, ld_cyc[ld_idx] - sh_cyc[base + nsh - 1], 1);
        end
    endtask

    initial begin
        vecs[0] = '{b8: 1'b1, par: 1'b0, word: 10'h1A5, nsh: 9};   // 8N1 0xA5
        vecs[1] = '{b8: 1'b0, par: 1'b1, word: 10'h135, nsh: 9};   // 7 data + parity
        vecs[2] = '{b8: 1'b1, par: 1'b1, word: 10'h33C, nsh: 10};  // 8 data + parity
        vecs[3] = '{b8: 1'b0, par: 1'b0, word: 10'h0CB, nsh: 8};   // 7N1

        // Reset held 3 Clk with the line toggling
        Rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            Rx_in = ~Rx_in;
            chk($sformatf("reset%0d_rx_bit", i), int'(rx_bit), 1);
            chk($sformatf("reset%0d_strobes", i), int'({shift, ld, busy, false_start}), 0);
        end
        Rx_in = 1'b1;
        @(negedge Clk);
        Rst = 1'b1;
        repeat (4) @(negedge Clk);

        // Table-driven frame formats
        for (int v = 0; v < 4; v++) begin
            bit8_en = vecs[v].b8;
            parity_en = vecs[v].par;
            clear_q();
            send_frame(vecs[v].word, vecs[v].nsh, edge_a);
            repeat (20) @(negedge Clk);
            chk($sformatf("vec%0d_shift_count", v), sh_cyc.size(), vecs[v].nsh);
            chk($sformatf("vec%0d_ld_count", v), ld_cyc.size(), 1);
            check_frame($sformatf("vec%0d", v), 0, 0, edge_a, vecs[v].word, vecs[v].nsh);
            if (ld_busy.size() > 0) chk($sformatf("vec%0d_busy_at_ld", v), int'(ld_busy[0]), 1);
            if (post_busy.size() > 0) chk($sformatf("vec%0d_busy_after_ld", v), int'(post_busy[0]), 0);
        end

        // Glitch: line low for 12 Clk only
        bit8_en = 1'b1; parity_en = 1'b0;
        clear_q();
        Rx_in = 1'b0;
        edge_a = cyc;
        repeat (12) @(negedge Clk);
        Rx_in = 1'b1;
        repeat (60) @(negedge Clk);
        chk("glitch_fs_count", fs_cyc.size(), 1);
        if (fs_cyc.size() > 0) begin
            chk("glitch_fs_time", int'((fs_cyc[0] - edge_a) >= 28 && (fs_cyc[0] - edge_a) <= 36), 1);
            chk("glitch_busy_at_fs", int'(fs_busy[0]), 0);
        end
        chk("glitch_no_shift", sh_cyc.size(), 0);
        chk("glitch_no_ld", ld_cyc.size(), 0);
        chk("glitch_busy_after", int'(busy), 0);

        // Back-to-back frames, no gap after the stop bit
        clear_q();
        send_frame(10'h1A5, 9, edge_a);
        send_frame(10'h15A, 9, edge_b);
        repeat (20) @(negedge Clk);
        chk("b2b_shift_count", sh_cyc.size(), 18);
        chk("b2b_ld_count", ld_cyc.size(), 2);
        check_frame("b2b_a", 0, 0, edge_a, 10'h1A5, 9);
        check_frame("b2b_b", 9, 1, edge_b, 10'h15A, 9);

        // rx_en dropped mid-frame: current frame completes, next start ignored
        clear_q();
        sender_done = 1'b0;
        fork
            begin
                send_frame(10'h1A5, 9, edge_a);
                send_frame(10'h100, 9, edge_b);
                sender_done = 1'b1;
            end
        join_none
        repeat (300) @(negedge Clk);
        rx_en = 1'b0;
        for (int i = 0; i < 2000 && !sender_done; i++) @(negedge Clk);
        chk("rxen_sender_done", int'(sender_done), 1);
        repeat (20) @(negedge Clk);
        chk("rxen_shift_count", sh_cyc.size(), 9);
        chk("rxen_ld_count", ld_cyc.size(), 1);
        check_frame("rxen", 0, 0, edge_a, 10'h1A5, 9);
        rx_en = 1'b1;
        repeat (4) @(negedge Clk);

        // Reset after the 4th shift abandons the frame
        clear_q();
        sender_done = 1'b0;
        fork
            begin
                send_frame(10'h1F0, 9, edge_a);
                sender_done = 1'b1;
            end
        join_none
        for (int i = 0; i < 2000 && sh_cyc.size() < 4; i++) @(negedge Clk);
        chk("rst_mid_reached_4_shifts", sh_cyc.size(), 4);
        Rst = 1'b0;
        @(negedge Clk);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_ld", int'(ld), 0);
        for (int i = 0; i < 2000 && !sender_done; i++) @(negedge Clk);
        chk("rst_mid_sender_done", int'(sender_done), 1);
        @(negedge Clk);
        Rst = 1'b1;
        repeat (10) @(negedge Clk);
        chk("rst_mid_no_ld", ld_cyc.size(), 0);
        chk("rst_mid_shift_total", sh_cyc.size(), 4);
        clear_q();
        send_frame(10'h1A5, 9, edge_a);
        repeat (20) @(negedge Clk);
        chk("post_rst_shift_count", sh_cyc.size(), 9);
        chk("post_rst_ld_count", ld_cyc.size(), 1);
        check_frame("post_rst", 0, 0, edge_a, 10'h1A5, 9);

        chk("shift_ld_never_together", overlap_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
